// File: rtl/leitor_display_pkg.sv
// Shared definitions for the 7-segment path (encoder and reader use the same truth table).
package leitor_display_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned CODE_W = 2;
   localparam int unsigned ERR_W  = 4;

   // Segment order {a,b,c,d,e,f,g}, 1 = segment lit
   localparam logic [SEG_W-1:0] SEG_COD00   = 7'b0001100;
   localparam logic [SEG_W-1:0] SEG_COD01   = 7'b1111010;
   localparam logic [SEG_W-1:0] SEG_COD10   = 7'b1111100;
   localparam logic [SEG_W-1:0] SEG_COD11   = 7'b1110011;
   localparam logic [SEG_W-1:0] SEG_APAGADO = 7'b0000000;

   typedef enum logic [1:0] {
      CONTANDO = 2'd0,
      TRAVADO  = 2'd1,
      ERRO     = 2'd2,
      APAGADO  = 2'd3
   } estado_t;

   typedef struct packed {
      logic              legal;
      logic              blank;
      logic [CODE_W-1:0] code;
   } decod_t;

endpackage

// File: rtl/leitor_display_decodificador_segmentos.sv
// Combinational 7-segment pattern classifier: legal code, blank or illegal.
module decodificador_segmentos
   import leitor_display_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output decod_t           decod_c
);

   // Map each known pattern to its code; anything else stays illegal
   always_comb begin
      decod_c = '0;
      case (seg)
         SEG_COD00: begin
            decod_c.legal = 1'b1;
            decod_c.code  = 2'b00;
         end
         SEG_COD01: begin
            decod_c.legal = 1'b1;
            decod_c.code  = 2'b01;
         end
         SEG_COD10: begin
            decod_c.legal = 1'b1;
            decod_c.code  = 2'b10;
         end
         SEG_COD11: begin
            decod_c.legal = 1'b1;
            decod_c.code  = 2'b11;
         end
         SEG_APAGADO: decod_c.blank = 1'b1;
         default:     decod_c = '0;
      endcase
   end

endmodule

// File: rtl/leitor_display.sv
// Segment readback: waits for a stable pattern, then decodes it to {y1,y0} or flags it.
module leitor_display
   import leitor_display_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seg_a,
   input  logic             seg_b,
   input  logic             seg_c,
   input  logic             seg_d,
   input  logic             seg_e,
   input  logic             seg_f,
   input  logic             seg_g,
   output logic             y1,
   output logic             y0,
   output logic             valid,
   output logic             travado,
   output logic             erro,
   output logic [ERR_W-1:0] n_erros
);

   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic [SEG_W-1:0] seg_in;
   logic [SEG_W-1:0] seg_q;
   logic [CNT_W-1:0] cnt;
   logic             mudou;
   estado_t          estado;
   decod_t           decod_c;

   assign seg_in = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
   assign mudou  = (seg_in != seg_q);

   // Decision uses the captured sample, which equals the input whenever a decision is taken
   decodificador_segmentos u_decod (
      .seg     (seg_q),
      .decod_c (decod_c)
   );

   // Capture, stability count, decision FSM and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q   <= SEG_APAGADO;
         cnt     <= '0;
         estado  <= CONTANDO;
         y1      <= 1'b0;
         y0      <= 1'b0;
         valid   <= 1'b0;
         travado <= 1'b0;
         erro    <= 1'b0;
         n_erros <= '0;
      end else begin
         seg_q <= seg_in;
         valid <= 1'b0;
         case (estado)
            CONTANDO: begin
               if (mudou) begin
                  cnt <= '0;
               end else if (cnt != CNT_FIM) begin
                  cnt <= cnt + CNT_W'(1);
               end else begin
                  cnt <= '0;
                  if (decod_c.legal) begin
                     y1      <= decod_c.code[1];
                     y0      <= decod_c.code[0];
                     valid   <= 1'b1;
                     travado <= 1'b1;
                     erro    <= 1'b0;
                     estado  <= TRAVADO;
                  end else if (decod_c.blank) begin
                     estado <= APAGADO;
                  end else begin
                     erro <= 1'b1;
                     if (n_erros != ERR_MAX) begin
                        n_erros <= n_erros + ERR_W'(1);
                     end
                     estado <= ERRO;
                  end
               end
            end
            default: begin
               // Locked, error or blank: hold until the pattern moves
               if (mudou) begin
                  travado <= 1'b0;
                  cnt     <= '0;
                  estado  <= CONTANDO;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_leitor_display.sv
// Bench for leitor_display: scoreboard of expected valid pulses plus directed level checks.
module tb_leitor_display;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg;
   logic [6:0] seg2;

   logic       y1, y0, valid, travado, erro;
   logic [3:0] n_erros;
   logic       y1_2, y0_2, valid_2, travado_2, erro_2;
   logic [3:0] n_erros_2;

   int checks   = 0;
   int failures = 0;
   bit mon_on   = 1'b0;

   logic [1:0] exp_q[$];
   logic [1:0] exp_q2[$];

   always #5 clk = ~clk;

   leitor_display #(.STABLE_CYCLES(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .seg_a(seg[6]), .seg_b(seg[5]), .seg_c(seg[4]), .seg_d(seg[3]),
      .seg_e(seg[2]), .seg_f(seg[1]), .seg_g(seg[0]),
      .y1(y1), .y0(y0), .valid(valid), .travado(travado), .erro(erro),
      .n_erros(n_erros)
   );

   leitor_display #(.STABLE_CYCLES(2), .CNT_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .seg_a(seg2[6]), .seg_b(seg2[5]), .seg_c(seg2[4]), .seg_d(seg2[3]),
      .seg_e(seg2[2]), .seg_f(seg2[1]), .seg_g(seg2[0]),
      .y1(y1_2), .y0(y0_2), .valid(valid_2), .travado(travado_2), .erro(erro_2),
      .n_erros(n_erros_2)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every valid pulse must match the next expected code; erro/travado exclusive
   always @(negedge clk) begin
      if (mon_on) begin
         chk("excl_erro_travado", {7'd0, erro & travado}, 8'd0);
         chk("excl_erro_travado_2", {7'd0, erro_2 & travado_2}, 8'd0);
         if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 8'd1, 8'd0);
            end else begin
               logic [1:0] e;
               e = exp_q.pop_front();
               chk("valid_code", {6'd0, y1, y0}, {6'd0, e});
               chk("valid_travado", {7'd0, travado}, 8'd1);
               chk("valid_erro", {7'd0, erro}, 8'd0);
            end
         end
         if (valid_2 === 1'b1) begin
            if (exp_q2.size() == 0) begin
               chk("unexpected_valid_2", 8'd1, 8'd0);
            end else begin
               logic [1:0] e;
               e = exp_q2.pop_front();
               chk("valid_code_2", {6'd0, y1_2, y0_2}, {6'd0, e});
               chk("valid_travado_2", {7'd0, travado_2}, 8'd1);
            end
         end
      end
   end

   initial begin
      logic [6:0] ilegal [2];
      int         nexp;
      ilegal[0] = 7'b1010101;
      ilegal[1] = 7'b0110110;

      // 1: reset, then lock 01 with exact latency, then no repeat pulses
      rst_n = 1'b0;
      seg   = 7'b0000000;
      seg2  = 7'b0000000;
      wait_edges(2);
      chk("rst_y", {6'd0, y1, y0}, 8'd0);
      chk("rst_valid", {7'd0, valid}, 8'd0);
      chk("rst_travado", {7'd0, travado}, 8'd0);
      chk("rst_erro", {7'd0, erro}, 8'd0);
      chk("rst_n_erros", {4'd0, n_erros}, 8'd0);
      mon_on = 1'b1;
      rst_n  = 1'b1;
      wait_edges(6);
      seg = 7'b1111010;
      exp_q.push_back(2'b01);
      wait_edges(4);
      chk("t1_before_lock", {7'd0, travado}, 8'd0);
      chk("t1_no_valid_early", {7'd0, valid}, 8'd0);
      wait_edges(1);
      chk("t1_valid", {7'd0, valid}, 8'd1);
      chk("t1_travado", {7'd0, travado}, 8'd1);
      chk("t1_y", {6'd0, y1, y0}, 8'd1);
      wait_edges(1);
      chk("t1_valid_one_cycle", {7'd0, valid}, 8'd0);
      wait_edges(20);
      chk("t1_still_locked", {7'd0, travado}, 8'd1);

      // 2: short pattern discarded, following pattern decoded
      seg = 7'b1110011;
      wait_edges(3);
      seg = 7'b0001100;
      exp_q.push_back(2'b00);
      wait_edges(6);
      chk("t2_y", {6'd0, y1, y0}, 8'd0);
      chk("t2_travado", {7'd0, travado}, 8'd1);

      // 3: illegal pattern flagged, then cleared by a legal one
      seg = 7'b1010101;
      wait_edges(6);
      chk("t3_erro", {7'd0, erro}, 8'd1);
      chk("t3_n_erros", {4'd0, n_erros}, 8'd1);
      chk("t3_travado", {7'd0, travado}, 8'd0);
      chk("t3_y_held", {6'd0, y1, y0}, 8'd0);
      seg = 7'b1111100;
      exp_q.push_back(2'b10);
      wait_edges(6);
      chk("t3_y10", {6'd0, y1, y0}, 8'd2);
      chk("t3_erro_clr", {7'd0, erro}, 8'd0);

      // 4: illegal/blank alternation saturates the error counter
      for (int k = 0; k < 16; k++) begin
         seg = ilegal[k % 2];
         wait_edges(6);
         nexp = (k + 2 > 15) ? 15 : k + 2;
         chk("t4_n_erros", {4'd0, n_erros}, 8'(nexp));
         seg = 7'b0000000;
         wait_edges(6);
         chk("t4_erro_held_blank", {7'd0, erro}, 8'd1);
      end
      chk("t4_saturated", {4'd0, n_erros}, 8'd15);

      // 5: reset mid-lock, relock after release
      seg = 7'b1111100;
      exp_q.push_back(2'b10);
      wait_edges(6);
      chk("t5_locked", {7'd0, travado}, 8'd1);
      rst_n = 1'b0;
      wait_edges(1);
      chk("t5_rst_y", {6'd0, y1, y0}, 8'd0);
      chk("t5_rst_valid", {7'd0, valid}, 8'd0);
      chk("t5_rst_travado", {7'd0, travado}, 8'd0);
      chk("t5_rst_erro", {7'd0, erro}, 8'd0);
      chk("t5_rst_n_erros", {4'd0, n_erros}, 8'd0);
      rst_n = 1'b1;
      exp_q.push_back(2'b10);
      wait_edges(4);
      chk("t5_no_lock_yet", {7'd0, travado}, 8'd0);
      wait_edges(1);
      chk("t5_valid", {7'd0, valid}, 8'd1);
      chk("t5_y", {6'd0, y1, y0}, 8'd2);

      // 6: short-stability instance, latency 2 and glitch relock
      seg2 = 7'b0001100;
      exp_q2.push_back(2'b00);
      wait_edges(2);
      chk("t6_no_lock_yet", {7'd0, travado_2}, 8'd0);
      wait_edges(1);
      chk("t6_valid", {7'd0, valid_2}, 8'd1);
      chk("t6_travado", {7'd0, travado_2}, 8'd1);
      wait_edges(4);
      seg2 = 7'b0000000;
      wait_edges(1);
      chk("t6_glitch_drop", {7'd0, travado_2}, 8'd0);
      seg2 = 7'b0001100;
      exp_q2.push_back(2'b00);
      wait_edges(3);
      chk("t6_relock", {7'd0, travado_2}, 8'd1);
      chk("t6_relock_y", {6'd0, y1_2, y0_2}, 8'd0);
      chk("t6_no_erro", {7'd0, erro_2}, 8'd0);

      wait_edges(4);
      chk("pending_valid", 8'(exp_q.size()), 8'd0);
      chk("pending_valid_2", 8'(exp_q2.size()), 8'd0);
      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/leitor_display.md
Name: leitor_display

Overview:
Receiving end of the 2-bit code → 7-segment display path. Samples the seven segment lines, waits for a pattern to hold stable for a programmable number of cycles, then decodes it back to the 2-bit code {y1,y0}. Flags illegal patterns and counts them. Used to close the loop on the display encoder: in self-check benches and as an on-board readback monitor.

Parameters:
STABLE_CYCLES, 4, number of consecutive rising edges a captured pattern must stay unchanged before decision; legal range 2..15.
CNT_W, 4, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g  input  1 each  segment lines; vector order {a,b,c,d,e,f,g}; 1 = segment on.
y1  output  1  decoded code, MSB.
y0  output  1  decoded code, LSB.
valid  output  1  one-cycle pulse when a new legal decision is made.
travado  output  1  level; high while the current stable pattern is legal and locked.
erro  output  1  level; high after an illegal stable pattern.
n_erros  output  4  saturating count of illegal decisions.

Behaviour:
- One clock (clk). Reset is synchronous and active-low: rst_n sampled low at a rising edge resets the block.
- Reset values: y1=0, y0=0, valid=0, travado=0, erro=0, n_erros=0, captured pattern seg_q=7'b0000000, stability counter cnt=0, state CONTANDO.
- Legal patterns ({a..g} → {y1,y0}):
  - 0001100 → 00
  - 1111010 → 01
  - 1111100 → 10
  - 1110011 → 11
- Blank: 0000000. Never produces valid or erro; y holds.
- Any other pattern is illegal.
- Input stage: seg_q registers the segment vector every edge. A "change" means the new sample differs from the current seg_q.
- States:
  - CONTANDO
    - On change: cnt ← 0, stay.
    - Unchanged and cnt < STABLE_CYCLES-1: cnt ← cnt+1.
    - Unchanged and cnt == STABLE_CYCLES-1: decide.
      - Legal: y ← code, valid pulse, travado ← 1, erro ← 0, go to TRAVADO.
      - Illegal: erro ← 1, n_erros ← n_erros+1 (saturating at 15), go to ERRO.
      - Blank: go to APAGADO.
  - TRAVADO / ERRO / APAGADO
    - Hold all outputs while unchanged.
    - On change: travado ← 0, cnt ← 0, go to CONTANDO.
    - erro and y keep their values until the next decision.
- Latency: pattern captured at edge E0 and held → decision and outputs update at edge E0+STABLE_CYCLES. valid is high for exactly the cycle after that edge.
- A change at any edge before the decision edge restarts the count from that edge. Glitches shorter than STABLE_CYCLES never produce valid or erro.
- The same legal pattern re-locked after an intermediate different pattern produces a new valid pulse, even if the code is unchanged.
- Reset mid-count or mid-lock: all state returns to the reset values at that edge. No valid pulse is emitted on the reset edge.
- valid and travado never both rise for an illegal pattern. erro and travado are never both 1.

Decomposition:
- Shared package leitor_display_pkg:
  - Segment pattern constants SEG_COD00, SEG_COD01, SEG_COD10, SEG_COD11, SEG_APAGADO.
  - State enum {CONTANDO, TRAVADO, ERRO, APAGADO}.
  - The same package is used by the encoder side, so both ends share one truth table.
- One combinational sub-module decodificador_segmentos: 7-bit pattern → {legal, blank, code[1:0]}.

Test Plan:
1. Reset, then hold 1111010 → at E0+4: y1y0=01, valid one-cycle pulse, travado=1, erro=0. Keep holding 20 cycles → no further valid.
2. Hold 1110011 for 3 cycles, then 0001100 held → no decision for the first pattern; at the second pattern's E0+4: y=00, valid once.
3. Hold 1010101 → at E0+4: erro=1, n_erros=1, travado=0, y unchanged. Follow with 1111100 → y=10, valid, erro=0.
4. Sixteen alternating illegal/blank stable patterns → n_erros saturates at 15, never wraps to 0.
5. Lock 1111100, drive rst_n=0 for one edge mid-lock, then release with 1111100 still applied → all outputs 0 after the reset edge; valid and y=10 again 4 edges after release.
6. STABLE_CYCLES=2 build: 0001100 held → decision at E0+2; a one-cycle glitch to 0000000 inside a lock → travado drops, then relocks with a fresh valid.
